// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a dual 4-to-1 mux with active-low strobes.
// Steps the select through all four indices and assembles the Y1/Y2 samples into two words.
module mux_scan_sequencer #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       en1,
    input  logic       en2,
    input  logic       Y1,
    input  logic       Y2,
    output logic [1:0] A,
    output logic       S1_n,
    output logic       S2_n,
    output logic       busy,
    output logic       done,
    output logic [3:0] word1,
    output logic [3:0] word2
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ch1_on_q, ch1_on_d;
    logic       ch2_on_q, ch2_on_d;
    logic [3:0] shadow1_q, shadow1_d;
    logic [3:0] shadow2_q, shadow2_d;
    logic [3:0] word1_q, word1_d;
    logic [3:0] word2_q, word2_d;

    logic sample_now;
    assign sample_now = (state_q == ST_SCAN) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_SCAN;
            ST_SCAN: if (sample_now && (idx_q == 2'd3)) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        A    = 2'd0;
        S1_n = 1'b1;
        S2_n = 1'b1;
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_SCAN: begin
                A    = idx_q;
                S1_n = ~ch1_on_q;
                S2_n = ~ch2_on_q;
                busy = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: the final sample is merged into the words on the same edge that enters DONE.
    always_comb begin
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        ch1_on_d  = ch1_on_q;
        ch2_on_d  = ch2_on_q;
        shadow1_d = shadow1_q;
        shadow2_d = shadow2_q;
        word1_d   = word1_q;
        word2_d   = word2_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ch1_on_d  = en1;
                    ch2_on_d  = en2;
                    idx_d     = 2'd0;
                    cnt_d     = 4'd0;
                    shadow1_d = 4'd0;
                    shadow2_d = 4'd0;
                end
            end
            ST_SCAN: begin
                if (sample_now) begin
                    shadow1_d[idx_q] = Y1;
                    shadow2_d[idx_q] = Y2;
                    cnt_d            = 4'd0;
                    if (idx_q == 2'd3) begin
                        word1_d = shadow1_d;
                        word2_d = shadow2_d;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= 2'd0;
            cnt_q     <= 4'd0;
            ch1_on_q  <= 1'b0;
            ch2_on_q  <= 1'b0;
            shadow1_q <= 4'd0;
            shadow2_q <= 4'd0;
            word1_q   <= 4'd0;
            word2_q   <= 4'd0;
        end else begin
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            ch1_on_q  <= ch1_on_d;
            ch2_on_q  <= ch2_on_d;
            shadow1_q <= shadow1_d;
            shadow2_q <= shadow2_d;
            word1_q   <= word1_d;
            word2_q   <= word2_d;
        end
    end

    assign word1 = word1_q;
    assign word2 = word2_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: a behavioural dual 4-to-1 mux feeds Y back, and every
// scan is checked cycle by cycle against timing and words derived from the scan rules.
module tb_mux_scan_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance a: SETTLE=2; instance b: SETTLE=1 for back-to-back scans.
    logic       rst_n;
    logic       start_a, en1_a, en2_a, y1_a, y2_a;
    logic [1:0] a_a;
    logic       s1n_a, s2n_a, busy_a, done_a;
    logic [3:0] w1_a, w2_a, d1_a, d2_a;

    logic       start_b, y1_b, y2_b;
    logic [1:0] a_b;
    logic       s1n_b, s2n_b, busy_b, done_b;
    logic [3:0] w1_b, w2_b, d1_b, d2_b;

    // Mux with active-low strobes: a disabled half outputs 0.
    assign y1_a = s1n_a ? 1'b0 : d1_a[a_a];
    assign y2_a = s2n_a ? 1'b0 : d2_a[a_a];
    assign y1_b = s1n_b ? 1'b0 : d1_b[a_b];
    assign y2_b = s2n_b ? 1'b0 : d2_b[a_b];

    mux_scan_sequencer #(.SETTLE(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .en1(en1_a), .en2(en2_a),
        .Y1(y1_a), .Y2(y2_a), .A(a_a), .S1_n(s1n_a), .S2_n(s2n_a),
        .busy(busy_a), .done(done_a), .word1(w1_a), .word2(w2_a)
    );

    mux_scan_sequencer #(.SETTLE(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .en1(1'b1), .en2(1'b1),
        .Y1(y1_b), .Y2(y2_b), .A(a_b), .S1_n(s1n_b), .S2_n(s2n_b),
        .busy(busy_b), .done(done_b), .word1(w1_b), .word2(w2_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0] d1;
        logic [3:0] d2;
        logic       en1;
        logic       en2;
    } vec_t;

    // Reference: a scan of SETTLE=2 holds index k/2 for busy cycle k, words are D when enabled else 0.
    task automatic run_scan(input vec_t v, input int repulse_at);
        logic [3:0] exp1, exp2;
        exp1 = v.en1 ? v.d1 : 4'd0;
        exp2 = v.en2 ? v.d2 : 4'd0;
        @(negedge clk);
        d1_a = v.d1; d2_a = v.d2; en1_a = v.en1; en2_a = v.en2; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        en1_a = ~v.en1; en2_a = ~v.en2;
        for (int k = 0; k < 8; k++) begin
            chk("busy", int'(busy_a), 1);
            chk("done_low", int'(done_a), 0);
            chk("sel", int'(a_a), k / 2);
            chk("s1_n", int'(s1n_a), int'(!v.en1));
            chk("s2_n", int'(s2n_a), int'(!v.en2));
            start_a = (k == repulse_at);
            @(negedge clk);
        end
        start_a = 1'b0;
        chk("done", int'(done_a), 1);
        chk("busy_in_done", int'(busy_a), 0);
        chk("word1", int'(w1_a), int'(exp1));
        chk("word2", int'(w2_a), int'(exp2));
        chk("strobes_done", int'({s1n_a, s2n_a}), 3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_busy", int'(busy_a), 0);
            chk("idle_done", int'(done_a), 0);
        end
        $display("scan d1=%b d2=%b en=%b%b -> word1=%b word2=%b", v.d1, v.d2, v.en1, v.en2, w1_a, w2_a);
    endtask

    vec_t vecs[4];
    vec_t rv;

    initial begin
        vecs[0] = '{d1: 4'b1010, d2: 4'b0110, en1: 1'b1, en2: 1'b1};
        vecs[1] = '{d1: 4'b1111, d2: 4'b1001, en1: 1'b0, en2: 1'b1};
        vecs[2] = '{d1: 4'b0011, d2: 4'b1100, en1: 1'b0, en2: 1'b0};
        vecs[3] = '{d1: 4'b1001, d2: 4'b0111, en1: 1'b1, en2: 1'b0};

        rst_n = 1'b0; start_a = 1'b0; en1_a = 1'b0; en2_a = 1'b0;
        d1_a = 4'd0; d2_a = 4'd0; start_b = 1'b0; d1_b = 4'b0101; d2_b = 4'b1110;
        #1;
        chk("rst_sel", int'(a_a), 0);
        chk("rst_strobes", int'({s1n_a, s2n_a}), 3);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_words", int'({w1_a, w2_a}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) run_scan(vecs[i], -1);
        for (int i = 0; i < 8; i++) begin
            rv.d1 = 4'($urandom); rv.d2 = 4'($urandom);
            rv.en1 = 1'($urandom); rv.en2 = 1'($urandom);
            run_scan(rv, -1);
        end

        // Start re-pulsed on the third busy cycle must not extend or repeat the scan.
        run_scan(vecs[0], 2);

        // Words hold after done even if the mux data changes.
        d1_a = 4'b0000;
        repeat (5) @(negedge clk);
        chk("hold_word1", int'(w1_a), 4'b1010);

        // Asynchronous reset in the fifth busy cycle, between clock edges.
        start_a = 1'b1; en1_a = 1'b1; en2_a = 1'b1; d1_a = 4'b1111; d2_a = 4'b1111;
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", int'(busy_a), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_strobes", int'({s1n_a, s2n_a}), 3);
        chk("mid_rst_busy", int'(busy_a), 0);
        chk("mid_rst_words", int'({w1_a, w2_a}), 0);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("post_rst_done", int'(done_a), 0);
            chk("post_rst_busy", int'(busy_a), 0);
        end

        // SETTLE=1 with start held: period of 6 cycles (4 busy, 1 done, 1 idle).
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 24; k++) begin
            chk("b2b_busy", int'(busy_b), int'((k % 6) < 4));
            chk("b2b_done", int'(done_b), int'((k % 6) == 4));
            if ((k % 6) < 4) chk("b2b_sel", int'(a_b), k % 6);
            if ((k % 6) == 4) begin
                chk("b2b_word1", int'(w1_b), 4'b0101);
                chk("b2b_word2", int'(w2_b), 4'b1110);
                $display("b2b scan done at cycle %0d word1=%b word2=%b", k, w1_b, w2_b);
            end
            @(negedge clk);
        end
        start_b = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Sequencer that sits around the dual 4-to-1 mux (153-style, active-low strobes), one stage upstream and downstream of it.
- Drives the mux select and strobe lines through all four data indices, waits for settling, and samples the mux outputs Y1/Y2.
- Assembles the samples into two 4-bit words, reconstructing the D1/D2 inputs as seen through the mux.
- Start/busy/done handshake to the controlling logic.

Parameters:
- SETTLE, 2, cycles each select index is held before its sample is taken; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a scan; sampled only in IDLE
- en1  input  1  scan channel 1 (mux half 1); captured at start
- en2  input  1  scan channel 2 (mux half 2); captured at start
- Y1  input  1  mux output, channel 1
- Y2  input  1  mux output, channel 2
- A  output  2  mux select, drives mux A[1:0]
- S1_n  output  1  active-low strobe to mux channel 1
- S2_n  output  1  active-low strobe to mux channel 2
- busy  output  1  high while a scan is in progress
- done  output  1  one-cycle pulse: word1/word2 updated
- word1  output  4  captured channel-1 word, bit i = Y1 sampled with A=i
- word2  output  4  captured channel-2 word, bit i = Y2 sampled with A=i

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately without a clock edge):
  - A=0, S1_n=1, S2_n=1, busy=0, done=0, word1=0, word2=0.
  - Internal index, settle counter and shadow registers cleared; FSM goes to IDLE.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - Outputs: S1_n=S2_n=1, A=0, busy=0, done=0.
  - On a clock edge with start=1: latch en1/en2 into ch1_on/ch2_on, set idx=0 and cnt=0, clear the shadow words, go to SCAN.
- SCAN:
  - Outputs: busy=1, A=idx, S1_n=~ch1_on, S2_n=~ch2_on.
  - Each clock, cnt increments.
  - When cnt==SETTLE-1 at an edge: shadow1[idx]<=Y1, shadow2[idx]<=Y2, cnt<=0, idx<=idx+1.
  - If idx==3 on that edge, go to DONE instead of incrementing.
  - Each index occupies exactly SETTLE cycles; SCAN lasts 4*SETTLE cycles.
- DONE:
  - Lasts exactly 1 cycle: busy=0, done=1, S1_n=S2_n=1, A=0.
  - word1/word2 take the shadow values at the edge entering DONE and are visible during the DONE cycle.
  - Next state is always IDLE.
- Latency: start accepted at edge T0; done is high during the cycle beginning at edge T0+4*SETTLE. A new start is accepted no earlier than edge T0+4*SETTLE+2.
- Disabled channel: its strobe stays 1 for the whole scan. The mux then outputs 0, so the word for that channel is 0000. The block samples Y regardless and does not force the value.
- Both channels disabled: the scan still runs its full length; both words become 0000.
- start during SCAN or DONE is ignored, not queued. en1/en2 changes mid-scan are ignored.
- start held high continuously: back-to-back scans, with one DONE and one IDLE cycle between them.
- word1/word2 hold their value between done pulses; they change only at the edge entering DONE.
- Reset mid-scan: outputs return to reset values immediately (strobes deassert), partial shadow data is discarded, and the words revert to 0.
- Index wrap: idx is 2 bits and never wraps inside a scan; the exit happens at idx==3.

Test Plan:
- Mux with D1=1010, D2=0110, SETTLE=2, en1=en2=1, one start pulse:
  - A steps 0,1,2,3 with 2 cycles each; S1_n=S2_n=0 for 8 cycles.
  - Then done=1 for 1 cycle with word1=1010, word2=0110; busy=0 afterwards.
- en1=0, en2=1, D1=1111, D2=1001:
  - S1_n stays 1 throughout; word1=0000, word2=1001.
- SETTLE=1, D1=0101, start held high for 20 cycles:
  - Each scan spans 4 busy cycles; done pulses every 6 cycles; word1=0101 every time.
- start re-pulsed at the 3rd busy cycle:
  - Ignored; exactly one done pulse; busy duration unchanged (4*SETTLE).
- rst_n dropped at the 5th busy cycle (SETTLE=2), between clock edges:
  - Same instant: S1_n=S2_n=1, busy=0, word1=word2=0.
  - After release: no done pulse until a new start.
- Change D1 from 1010 to 0000 after done, with no new start:
  - word1 holds 1010.
